// File: rtl/board_pkg.sv
// Shared board-drawing definitions: screen size, palette, symbol ids,
// FSM state encoding and the 3x3 grid origins used by the control FSM.
package board_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] C_BLACK  = 3'b000;
    localparam logic [2:0] C_RED    = 3'b100;
    localparam logic [2:0] C_GREEN  = 3'b010;
    localparam logic [2:0] C_BLUE   = 3'b001;
    localparam logic [2:0] C_YELLOW = 3'b110;
    localparam logic [2:0] C_WHITE  = 3'b111;

    typedef enum logic [1:0] {
        SYM_RING    = 2'd0,
        SYM_X       = 2'd1,
        SYM_PLUS    = 2'd2,
        SYM_DIAMOND = 2'd3
    } sym_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } plot_state_e;

    // Top-left corners of the nine board cells (columns and rows).
    localparam logic [7:0] GRID_X0 = 8'd50;
    localparam logic [7:0] GRID_X1 = 8'd70;
    localparam logic [7:0] GRID_X2 = 8'd90;
    localparam logic [6:0] GRID_Y0 = 7'd30;
    localparam logic [6:0] GRID_Y1 = 7'd50;
    localparam logic [6:0] GRID_Y2 = 7'd70;

    // Foreground colour that belongs to each symbol.
    function automatic logic [2:0] sym_colour(input sym_e sym);
        logic [2:0] c;
        case (sym)
            SYM_RING:    c = C_RED;
            SYM_X:       c = C_GREEN;
            SYM_PLUS:    c = C_BLUE;
            SYM_DIAMOND: c = C_YELLOW;
            default:     c = C_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sprite_plotter_if.sv
// Draw-command and VGA pixel-write bundle between the board control FSM
// (master) and the sprite plotter (slave).
interface sprite_plotter_if;

    logic       start;
    logic [1:0] sym_id;
    logic [7:0] x_org;
    logic [6:0] y_org;

    logic       busy;
    logic       done;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;

    modport master (
        output start, sym_id, x_org, y_org,
        input  busy, done, x, y, colour, plot
    );

    modport slave (
        input  start, sym_id, x_org, y_org,
        output busy, done, x, y, colour, plot
    );

endinterface

// File: rtl/sprite_plotter_rom.sv
// Procedural sprite "ROM": decides whether pixel (col,row) of a symbol is
// foreground, and reports the symbol's foreground colour.
module sprite_rom
    import board_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16
) (
    input  sym_e                          sym,
    input  logic [$clog2(SPRITE_W)-1:0]   col,
    input  logic [$clog2(SPRITE_H)-1:0]   row,
    output logic                          fg,
    output logic [2:0]                    fg_colour
);

    // Shape tests are written relative to the sprite edges and centre so the
    // glyphs stay symmetric; dx/dy are doubled distances from the centre.
    always_comb begin : shape_lookup
        int c;
        int r;
        int dx;
        int dy;
        c  = int'(col);
        r  = int'(row);
        dx = 2 * c - (SPRITE_W - 1);
        dy = 2 * r - (SPRITE_H - 1);
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        fg = 1'b0;
        case (sym)
            SYM_RING:
                fg = (c == 2 || c == SPRITE_W - 3 || r == 2 || r == SPRITE_H - 3) &&
                     (c >= 2 && c <= SPRITE_W - 3 && r >= 2 && r <= SPRITE_H - 3);
            SYM_X:
                fg = (c == r) || (c + r == SPRITE_W - 1);
            SYM_PLUS:
                fg = (c == SPRITE_W / 2 - 1) || (c == SPRITE_W / 2) ||
                     (r == SPRITE_H / 2 - 1) || (r == SPRITE_H / 2);
            SYM_DIAMOND:
                fg = (dx + dy <= SPRITE_W - 2);
            default:
                fg = 1'b0;
        endcase
        fg_colour = sym_colour(sym);
    end

endmodule

// File: rtl/sprite_plotter.sv
// Renders one sprite at a requested origin, one VGA write per cycle, in
// raster order; clipped pixels still take their cycle so timing is fixed.
module sprite_plotter
    import board_pkg::*;
#(
    parameter int SPRITE_W = 16,
    parameter int SPRITE_H = 16
) (
    input  logic            clk,
    input  logic            reset,
    sprite_plotter_if.slave bus
);

    localparam int COL_W = $clog2(SPRITE_W);
    localparam int ROW_W = $clog2(SPRITE_H);

    plot_state_e      state;
    plot_state_e      next_state;
    sym_e             sym_q;
    logic [7:0]       x_org_q;
    logic [6:0]       y_org_q;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last_pixel;
    logic [8:0]       px;
    logic [7:0]       py;
    logic             clipped;
    logic             rom_fg;
    logic [2:0]       rom_fg_colour;

    assign last_pixel = (col == COL_W'(SPRITE_W - 1)) && (row == ROW_W'(SPRITE_H - 1));
    assign px         = {1'b0, x_org_q} + 9'(col);
    assign py         = {1'b0, y_org_q} + 8'(row);
    assign clipped    = (px > 9'(SCREEN_W - 1)) || (py > 8'(SCREEN_H - 1));

    sprite_rom #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H)
    ) u_rom (
        .sym       (sym_q),
        .col       (col),
        .row       (row),
        .fg        (rom_fg),
        .fg_colour (rom_fg_colour)
    );

    // State register; reset aborts any sprite in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next state: start only matters in IDLE, DONE lasts exactly one cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.start) next_state = DRAW;
            DRAW:    if (last_pixel) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Command latch, pixel counters and registered VGA outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sym_q      <= SYM_RING;
            x_org_q    <= '0;
            y_org_q    <= '0;
            col        <= '0;
            row        <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= '0;
            bus.plot   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    bus.plot <= 1'b0;
                    if (bus.start) begin
                        sym_q   <= sym_e'(bus.sym_id);
                        x_org_q <= bus.x_org;
                        y_org_q <= bus.y_org;
                        col     <= '0;
                        row     <= '0;
                    end
                end
                DRAW: begin
                    bus.busy   <= 1'b1;
                    bus.done   <= 1'b0;
                    bus.plot   <= ~clipped;
                    bus.x      <= px[7:0];
                    bus.y      <= py[6:0];
                    bus.colour <= rom_fg ? rom_fg_colour : C_WHITE;
                    col        <= col + COL_W'(1);
                    if (col == COL_W'(SPRITE_W - 1)) row <= row + ROW_W'(1);
                end
                DONE: begin
                    bus.busy <= 1'b1;
                    bus.done <= 1'b1;
                    bus.plot <= 1'b0;
                end
                default: begin
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                    bus.plot <= 1'b0;
                end
            endcase
        end
    end

endmodule
